// File: rtl/mpu_tl_pkg.sv
// rtl/mpu_tl_pkg.sv - shared TileLink D-channel payload type and opcodes
package mpu_tl_pkg;

  localparam logic [2:0] D_ACCESS_ACK      = 3'd0;
  localparam logic [2:0] D_ACCESS_ACK_DATA = 3'd1;
  localparam logic [2:0] D_HINT_ACK        = 3'd2;
  localparam logic [2:0] D_GRANT           = 3'd4;
  localparam logic [2:0] D_GRANT_DATA      = 3'd5;
  localparam logic [2:0] D_RELEASE_ACK     = 3'd6;

  // valid/ready live inside the payload but are carried as plain data here
  typedef struct packed {
    logic        valid;
    logic        ready;
    logic [2:0]  opcode;
    logic [1:0]  param;
    logic [2:0]  size;
    logic [7:0]  source;
    logic        sink;
    logic        denied;
    logic [31:0] data;
    logic        corrupt;
  } tl_d_channel;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_e;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin pick starting after the last winner
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic [NUM_REQ-1:0] gnt_onehot,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               any
);

  // Candidate index is formed one bit wider so the wrap works for any NUM_REQ.
  always_comb begin
    logic [IDX_W:0] cand;
    cand       = '0;
    gnt_onehot = '0;
    gnt_idx    = '0;
    any        = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = {1'b0, last} + (IDX_W+1)'(i);
      if (cand >= (IDX_W+1)'(NUM_REQ)) cand = cand - (IDX_W+1)'(NUM_REQ);
      if (!any && req[cand[IDX_W-1:0]]) begin
        any                         = 1'b1;
        gnt_idx                     = cand[IDX_W-1:0];
        gnt_onehot[cand[IDX_W-1:0]] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mpu_d_rr_arbiter.sv
// rtl/mpu_d_rr_arbiter.sv - round-robin D-channel response arbiter with registered output
module mpu_d_rr_arbiter
  import mpu_tl_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int IDX_W       = $clog2(NUM_REQ),
  parameter int STALL_LIMIT = 64,
  parameter int CNT_W       = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req_valid,
  input  tl_d_channel        req_bits [NUM_REQ],
  output logic [NUM_REQ-1:0] req_ready,
  output logic               d_valid,
  output tl_d_channel        d_bits,
  input  logic               d_ready,
  output logic [IDX_W-1:0]   d_grant_id,
  output logic               stall_err,
  input  logic               stall_clr
);

  out_state_e         state, state_nxt;
  logic               load;
  logic               grant;
  logic               any;
  logic [NUM_REQ-1:0] gnt_onehot;
  logic [IDX_W-1:0]   gnt_idx;
  logic [IDX_W-1:0]   last_grant;
  logic               stalled;
  logic [CNT_W-1:0]   wd_cnt, wd_nxt;

  rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
    .req        (req_valid),
    .last       (last_grant),
    .gnt_onehot (gnt_onehot),
    .gnt_idx    (gnt_idx),
    .any        (any)
  );

  assign load  = (state == ST_EMPTY) || d_ready;
  assign grant = load && any;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_EMPTY;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (load) state_nxt = any ? ST_FULL : ST_EMPTY;
  end

  always_comb begin
    d_valid   = (state == ST_FULL);
    req_ready = load ? gnt_onehot : '0;
  end

  // Payload and pointer move only on a real grant; an idle load just empties the stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_bits     <= '0;
      d_grant_id <= '0;
      last_grant <= IDX_W'(NUM_REQ - 1);
    end else if (grant) begin
      d_bits     <= req_bits[gnt_idx];
      d_grant_id <= gnt_idx;
      last_grant <= gnt_idx;
    end
  end

  assign stalled = d_valid && !d_ready;

  always_comb begin
    wd_nxt = '0;
    if (stalled) wd_nxt = (wd_cnt == CNT_W'(STALL_LIMIT)) ? wd_cnt : wd_cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt    <= '0;
      stall_err <= 1'b0;
    end else if (stall_clr) begin
      wd_cnt    <= '0;
      stall_err <= 1'b0;
    end else begin
      wd_cnt <= wd_nxt;
      if (wd_nxt == CNT_W'(STALL_LIMIT)) stall_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mpu_d_rr_arbiter.sv
// tb/tb_mpu_d_rr_arbiter.sv - self-checking bench for mpu_d_rr_arbiter
module tb_mpu_d_rr_arbiter;
  import mpu_tl_pkg::*;

  localparam int N     = 4;
  localparam int LIMIT = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  req_valid = '0;
  tl_d_channel   req_bits [N];
  logic [N-1:0]  req_ready;
  logic          d_valid;
  tl_d_channel   d_bits;
  logic          d_ready = 1'b0;
  logic [1:0]    d_grant_id;
  logic          stall_err;
  logic          stall_clr = 1'b0;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int          id;
    tl_d_channel bits;
  } sb_t;
  sb_t sb_q[$];

  int m_last;
  int m_wd;
  logic m_err;

  typedef struct {
    logic [N-1:0] rv;
    logic         dr;
    logic [N-1:0] exp_ready;
    logic         exp_dv;
    int           exp_gid;
  } vec_t;
  vec_t vecs[$];

  mpu_d_rr_arbiter #(.NUM_REQ(N), .STALL_LIMIT(LIMIT), .CNT_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_bits   (req_bits),
    .req_ready  (req_ready),
    .d_valid    (d_valid),
    .d_bits     (d_bits),
    .d_ready    (d_ready),
    .d_grant_id (d_grant_id),
    .stall_err  (stall_err),
    .stall_clr  (stall_clr)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Inputs are already driven; check before the edge, update the model, step past the edge.
  task automatic tick(input string tag);
    logic         full, load, found, stall_pre;
    int           w, c;
    logic [N-1:0] exp_rdy;
    sb_t          e;
    #2;
    full  = (sb_q.size() != 0);
    load  = !full || d_ready;
    found = 1'b0;
    w     = 0;
    for (int k = 1; k <= N; k++) begin
      c = (m_last + k) % N;
      if (!found && req_valid[c]) begin
        found = 1'b1;
        w     = c;
      end
    end
    exp_rdy = (load && found) ? N'(1 << w) : '0;
    chk({tag, ".req_ready"}, 64'(req_ready), 64'(exp_rdy));
    chk({tag, ".d_valid"}, 64'(d_valid), 64'(full));
    stall_pre = full && !d_ready;
    if (full && d_ready) begin
      e = sb_q.pop_front();
      chk({tag, ".sb_id"}, 64'(d_grant_id), 64'(e.id));
      chk({tag, ".sb_bits"}, 64'(d_bits), 64'(e.bits));
    end
    if (load && found) begin
      e.id   = w;
      e.bits = req_bits[w];
      sb_q.push_back(e);
      m_last = w;
    end
    @(posedge clk);
    #1;
    if (stall_clr) begin
      m_wd  = 0;
      m_err = 1'b0;
    end else begin
      m_wd = stall_pre ? ((m_wd == LIMIT) ? LIMIT : m_wd + 1) : 0;
      if (m_wd == LIMIT) m_err = 1'b1;
    end
    chk({tag, ".stall_err"}, 64'(stall_err), 64'(m_err));
  endtask

  task automatic model_reset();
    sb_q.delete();
    m_last = N - 1;
    m_wd   = 0;
    m_err  = 1'b0;
  endtask

  task automatic run_vecs(input string tag);
    for (int i = 0; i < vecs.size(); i++) begin
      req_valid = vecs[i].rv;
      d_ready   = vecs[i].dr;
      #1;
      chk($sformatf("%s[%0d].ready", tag, i), 64'(req_ready), 64'(vecs[i].exp_ready));
      chk($sformatf("%s[%0d].dv", tag, i), 64'(d_valid), 64'(vecs[i].exp_dv));
      if (vecs[i].exp_dv) begin
        chk($sformatf("%s[%0d].gid", tag, i), 64'(d_grant_id), 64'(vecs[i].exp_gid));
        chk($sformatf("%s[%0d].src", tag, i), 64'(d_bits.source), 64'(vecs[i].exp_gid));
      end
      tick($sformatf("%s[%0d]", tag, i));
    end
    vecs.delete();
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      req_bits[i]        = '0;
      req_bits[i].valid  = i[0];
      req_bits[i].ready  = i[1];
      req_bits[i].opcode = D_ACCESS_ACK_DATA;
      req_bits[i].size   = 3'd2;
      req_bits[i].source = 8'(i);
      req_bits[i].data   = 32'hA000_0000 + 32'(i);
    end
    model_reset();

    repeat (2) @(posedge clk);
    #1;
    chk("rst.d_valid", 64'(d_valid), 64'd0);
    chk("rst.d_bits", 64'(d_bits), 64'd0);
    chk("rst.gid", 64'(d_grant_id), 64'd0);
    chk("rst.stall_err", 64'(stall_err), 64'd0);
    chk("rst.req_ready", 64'(req_ready), 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) tick($sformatf("idle%0d", i));

    vecs.push_back('{4'b1111, 1'b1, 4'b0001, 1'b0, 0});
    vecs.push_back('{4'b1111, 1'b1, 4'b0010, 1'b1, 0});
    vecs.push_back('{4'b1111, 1'b1, 4'b0100, 1'b1, 1});
    vecs.push_back('{4'b1111, 1'b1, 4'b1000, 1'b1, 2});
    vecs.push_back('{4'b1111, 1'b1, 4'b0001, 1'b1, 3});
    vecs.push_back('{4'b1111, 1'b1, 4'b0010, 1'b1, 0});
    vecs.push_back('{4'b0000, 1'b1, 4'b0000, 1'b1, 1});
    run_vecs("rr_all");

    vecs.push_back('{4'b1010, 1'b1, 4'b1000, 1'b0, 0});
    vecs.push_back('{4'b1010, 1'b1, 4'b0010, 1'b1, 3});
    vecs.push_back('{4'b1010, 1'b1, 4'b1000, 1'b1, 1});
    vecs.push_back('{4'b0000, 1'b1, 4'b0000, 1'b1, 3});
    run_vecs("rr_1010");
    tick("drain1");

    req_bits[0].data = 32'hDEAD_BEEF;
    req_valid = 4'b0001;
    d_ready   = 1'b1;
    tick("hold_load");
    req_valid = 4'b0110;
    d_ready   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("hold%0d.data", i), 64'(d_bits.data), 64'hDEAD_BEEF);
      chk($sformatf("hold%0d.gid", i), 64'(d_grant_id), 64'd0);
      chk($sformatf("hold%0d.ready", i), 64'(req_ready), 64'd0);
      tick($sformatf("hold%0d", i));
    end
    d_ready = 1'b1;
    #1;
    chk("hold_release.ready", 64'(req_ready), 64'b0010);
    tick("hold_release");
    req_valid = 4'b0100;
    tick("hold_next");
    req_valid = 4'b0000;
    tick("hold_drain");
    tick("hold_empty");

    req_valid = 4'b0001;
    d_ready   = 1'b1;
    tick("wd_load");
    req_valid = 4'b0000;
    d_ready   = 1'b0;
    for (int i = 0; i < LIMIT; i++) begin
      tick($sformatf("wd_stall%0d", i));
      chk($sformatf("wd_stall%0d.err", i), 64'(stall_err), (i == LIMIT - 1) ? 64'd1 : 64'd0);
    end
    d_ready = 1'b1;
    tick("wd_ready");
    chk("wd_sticky", 64'(stall_err), 64'd1);
    stall_clr = 1'b1;
    tick("wd_clr");
    stall_clr = 1'b0;
    chk("wd_cleared", 64'(stall_err), 64'd0);

    req_valid = 4'b0001;
    d_ready   = 1'b0;
    tick("ar_load");
    req_valid = 4'b0100;
    #2;
    chk("ar_full", 64'(d_valid), 64'd1);
    rst = 1'b1;
    #1;
    chk("ar_drop", 64'(d_valid), 64'd0);
    chk("ar_bits", 64'(d_bits), 64'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst     = 1'b0;
    d_ready = 1'b1;
    #1;
    chk("ar_first.ready", 64'(req_ready), 64'b0100);
    tick("ar_first");
    req_valid = 4'b0000;
    chk("ar_first.gid", 64'(d_grant_id), 64'd2);
    tick("ar_drain");
    tick("ar_empty");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
